// File: rtl/axil_gpio_slave.sv
// rtl/axil_gpio_slave.sv - AXI-Lite GPIO responder: data/dir registers, synchronized inputs.
// Define GPIO_IRQ_EN to build the per-bit rising-edge interrupt (IRQ_EN / IRQ_STAT, irq_o).
module axil_gpio_slave #(
  parameter int GPIO_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [31:0]       s_axi_awaddr_i,
  input  logic              s_axi_awvalid_i,
  output logic              s_axi_awready_o,
  input  logic [31:0]       s_axi_wdata_i,
  input  logic              s_axi_wvalid_i,
  output logic              s_axi_wready_o,
  output logic              s_axi_bvalid_o,
  input  logic              s_axi_bready_i,
  input  logic [31:0]       s_axi_araddr_i,
  input  logic              s_axi_arvalid_i,
  output logic              s_axi_arready_o,
  output logic [31:0]       s_axi_rdata_o,
  output logic              s_axi_rvalid_o,
  input  logic              s_axi_rready_i,
  input  logic [GPIO_W-1:0] gpio_i,
  output logic [GPIO_W-1:0] gpio_o,
  output logic [GPIO_W-1:0] gpio_oe_o,
  output logic              irq_o
);
  typedef enum logic {W_IDLE, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;

  localparam logic [2:0] A_DATA_OUT = 3'd0;
  localparam logic [2:0] A_DATA_IN  = 3'd1;
  localparam logic [2:0] A_DIR      = 3'd2;

  w_state_e          w_state_q, w_state_d;
  r_state_e          r_state_q, r_state_d;
  logic              aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic [2:0]        awaddr_q, awaddr_d;
  logic [GPIO_W-1:0] wdata_q, wdata_d;
  logic              awready_q, awready_d, wready_q, wready_d, arready_q, arready_d;
  logic [31:0]       rdata_q, rdata_d, rd_val;
  logic [GPIO_W-1:0] data_out_q, data_out_d, dir_q, dir_d;
  logic [GPIO_W-1:0] sync1_q, sync2_q;
  logic              wr_en;
  logic [2:0]        wr_addr;
  logic [GPIO_W-1:0] wr_data;
  logic              unused_addr;

  assign unused_addr = ^{s_axi_awaddr_i[31:5], s_axi_awaddr_i[1:0],
                         s_axi_araddr_i[31:5], s_axi_araddr_i[1:0]};

  function automatic logic [31:0] zext(input logic [GPIO_W-1:0] v);
    logic [31:0] r;
    r = '0;
    r[GPIO_W-1:0] = v;
    return r;
  endfunction

  // AW and W are latched independently; the write commits on the edge both are held.
  always_comb begin
    w_state_d = w_state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wr_en     = 1'b0;
    wr_addr   = aw_done_q ? awaddr_q : s_axi_awaddr_i[4:2];
    wr_data   = w_done_q ? wdata_q : s_axi_wdata_i[GPIO_W-1:0];
    case (w_state_q)
      W_IDLE: begin
        if (s_axi_awvalid_i && awready_q) begin
          aw_done_d = 1'b1;
          awaddr_d  = s_axi_awaddr_i[4:2];
        end
        if (s_axi_wvalid_i && wready_q) begin
          w_done_d = 1'b1;
          wdata_d  = s_axi_wdata_i[GPIO_W-1:0];
        end
        if (aw_done_d && w_done_d) begin
          wr_en     = 1'b1;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          w_state_d = W_RESP;
        end
      end
      W_RESP:  if (s_axi_bready_i) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
    awready_d = (w_state_d == W_IDLE) && !aw_done_d;
    wready_d  = (w_state_d == W_IDLE) && !w_done_d;
  end

  always_comb begin
    data_out_d = data_out_q;
    dir_d      = dir_q;
    if (wr_en) begin
      case (wr_addr)
        A_DATA_OUT: data_out_d = wr_data;
        A_DIR:      dir_d      = wr_data;
        default:    ;
      endcase
    end
  end

`ifdef GPIO_IRQ_EN
  localparam logic [2:0] A_IRQ_EN   = 3'd3;
  localparam logic [2:0] A_IRQ_STAT = 3'd4;

  logic [GPIO_W-1:0] irq_en_q, irq_en_d, irq_stat_q, irq_stat_d, prev_q, stat_clr;
  logic              irq_q, irq_d;

  // A rising edge in the same cycle as a W1C clear keeps the bit set.
  always_comb begin
    irq_en_d = irq_en_q;
    stat_clr = '0;
    if (wr_en && (wr_addr == A_IRQ_EN))   irq_en_d = wr_data;
    if (wr_en && (wr_addr == A_IRQ_STAT)) stat_clr = wr_data;
    irq_stat_d = (irq_stat_q & ~stat_clr) | (sync2_q & ~prev_q & irq_en_q);
    irq_d      = |(irq_stat_d & irq_en_d);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      irq_en_q   <= '0;
      irq_stat_q <= '0;
      prev_q     <= '0;
      irq_q      <= 1'b0;
    end else begin
      irq_en_q   <= irq_en_d;
      irq_stat_q <= irq_stat_d;
      prev_q     <= sync2_q;
      irq_q      <= irq_d;
    end
  end

  assign irq_o = irq_q;
`else
  assign irq_o = 1'b0;
`endif

  // Read mux samples pre-edge register values, so a same-edge write returns the old value.
  always_comb begin
    case (s_axi_araddr_i[4:2])
      A_DATA_OUT: rd_val = zext(data_out_q);
      A_DATA_IN:  rd_val = zext(sync2_q);
      A_DIR:      rd_val = zext(dir_q);
`ifdef GPIO_IRQ_EN
      A_IRQ_EN:   rd_val = zext(irq_en_q);
      A_IRQ_STAT: rd_val = zext(irq_stat_q);
`endif
      default:    rd_val = '0;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    rdata_d   = rdata_q;
    case (r_state_q)
      R_IDLE: begin
        if (s_axi_arvalid_i && arready_q) begin
          rdata_d   = rd_val;
          r_state_d = R_DATA;
        end
      end
      R_DATA:  if (s_axi_rready_i) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
    arready_d = (r_state_d == R_IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      w_state_q  <= W_IDLE;
      r_state_q  <= R_IDLE;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      arready_q  <= 1'b0;
      rdata_q    <= '0;
      data_out_q <= '0;
      dir_q      <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
    end else begin
      w_state_q  <= w_state_d;
      r_state_q  <= r_state_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      arready_q  <= arready_d;
      rdata_q    <= rdata_d;
      data_out_q <= data_out_d;
      dir_q      <= dir_d;
      sync1_q    <= gpio_i;
      sync2_q    <= sync1_q;
    end
  end

  assign s_axi_awready_o = awready_q;
  assign s_axi_wready_o  = wready_q;
  assign s_axi_bvalid_o  = (w_state_q == W_RESP);
  assign s_axi_arready_o = arready_q;
  assign s_axi_rvalid_o  = (r_state_q == R_DATA);
  assign s_axi_rdata_o   = rdata_q;
  assign gpio_o          = data_out_q;
  assign gpio_oe_o       = dir_q;
endmodule

// File: tb/tb_axil_gpio_slave.sv
// tb/tb_axil_gpio_slave.sv - scoreboard bench for axil_gpio_slave (IRQ checks when GPIO_IRQ_EN defined).
module tb_axil_gpio_slave;
  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic        awready, wready, bvalid, arready, rvalid, irq;
  logic [31:0] rdata, gpio_in = '0, gpio_out, gpio_oe;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [31:0] exp_r_q[$];
  int          exp_b_q[$];

  axil_gpio_slave #(.GPIO_W(32)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .s_axi_awaddr_i(awaddr), .s_axi_awvalid_i(awvalid), .s_axi_awready_o(awready),
    .s_axi_wdata_i(wdata), .s_axi_wvalid_i(wvalid), .s_axi_wready_o(wready),
    .s_axi_bvalid_o(bvalid), .s_axi_bready_i(bready),
    .s_axi_araddr_i(araddr), .s_axi_arvalid_i(arvalid), .s_axi_arready_o(arready),
    .s_axi_rdata_o(rdata), .s_axi_rvalid_o(rvalid), .s_axi_rready_i(rready),
    .gpio_i(gpio_in), .gpio_o(gpio_out), .gpio_oe_o(gpio_oe), .irq_o(irq)
  );

  always #5 clk_i = ~clk_i;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endfunction

  // Read monitor: compares rdata against the queue head every rvalid cycle, pops on handshake.
  always @(negedge clk_i) begin
    if (rst_n_i && rvalid) begin
      if (exp_r_q.size() == 0) begin
        total_cnt++;
        $display("FAIL rdata_unexpected: got 0x%08h with no read pending", rdata);
      end else begin
        check("rdata", rdata, exp_r_q[0]);
        if (rready) void'(exp_r_q.pop_front());
      end
    end
  end

  // Write-response monitor: every B handshake must match one issued write.
  always @(negedge clk_i) begin
    if (rst_n_i && bvalid && bready) begin
      total_cnt++;
      if (exp_b_q.size() == 0) $display("FAIL bresp_unexpected: got extra bvalid, expected none");
      else begin
        pass_cnt++;
        void'(exp_b_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_b;
    int n = 0;
    logic done = 1'b0;
    while (!done && n < 20) begin
      @(negedge clk_i);
      done = bvalid && bready;
      tick();
      n++;
    end
    check("b_handshake", {31'd0, done}, 32'd1);
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data);
    int   n = 0;
    logic aw_hs, w_hs;
    exp_b_q.push_back(int'(addr));
    awaddr = addr; wdata = data; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    while ((awvalid || wvalid) && n < 20) begin
      @(negedge clk_i);
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      tick();
      if (aw_hs) awvalid = 1'b0;
      if (w_hs)  wvalid = 1'b0;
      n++;
    end
    check("aw_w_accept", {31'd0, (awvalid || wvalid)}, 32'd0);
    awvalid = 1'b0; wvalid = 1'b0;
    wait_b();
    @(negedge clk_i);
    check("bvalid_single_pulse", {31'd0, bvalid}, 32'd0);
    tick();
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [31:0] exp, input int stall);
    int   n = 0;
    logic done = 1'b0;
    exp_r_q.push_back(exp);
    araddr = addr; arvalid = 1'b1; rready = 1'b0;
    while (!done && n < 20) begin
      @(negedge clk_i);
      done = arready;
      tick();
      n++;
    end
    check("ar_accept", {31'd0, done}, 32'd1);
    arvalid = 1'b0;
    repeat (stall) tick();
    rready = 1'b1;
    done = 1'b0;
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk_i);
      done = rvalid;
      tick();
      n++;
    end
    check("r_handshake", {31'd0, done}, 32'd1);
    rready = 1'b0;
  endtask

  initial begin
    // Outputs during reset
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_ready_bits", {29'd0, awready, wready, arready}, 32'd0);
    check("rst_valid_bits", {29'd0, bvalid, rvalid, irq}, 32'd0);
    check("rst_gpio_o", gpio_out, 32'd0);
    check("rst_gpio_oe", gpio_oe, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    tick();
    rst_n_i = 1'b1;
    tick();
    @(negedge clk_i);
    check("post_rst_readies", {29'd0, awready, wready, arready}, 32'd7);
    tick();

    // Reset while AW is accepted and W is still pending
    awaddr = 32'h0; wdata = 32'hDEAD_BEEF; awvalid = 1'b1; wvalid = 1'b0;
    tick();
    awvalid = 1'b0;
    rst_n_i = 1'b0;
    @(negedge clk_i);
    check("midrst_readies", {29'd0, awready, wready, arready}, 32'd0);
    tick();
    rst_n_i = 1'b1;
    tick();
    @(negedge clk_i);
    check("midrst_bvalid", {31'd0, bvalid}, 32'd0);
    check("midrst_gpio_o", gpio_out, 32'd0);
    check("midrst_aw_w_ready", {30'd0, awready, wready}, 32'd3);
    tick();

    // AW and W together, DATA_OUT
    axi_write(32'h00, 32'hA5A5_0F0F);
    check("data_out_write", gpio_out, 32'hA5A5_0F0F);

    // W two cycles ahead of AW, DIR, response stalled for 3 cycles
    exp_b_q.push_back(8);
    wdata = 32'hFFFF_0000; wvalid = 1'b1; bready = 1'b0;
    tick();
    wvalid = 1'b0;
    tick();
    @(negedge clk_i);
    check("w_first_oe_unchanged", gpio_oe, 32'd0);
    check("w_first_ready_bits", {29'd0, awready, wready, bvalid}, 32'b100);
    awaddr = 32'h08; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    check("dir_write", gpio_oe, 32'hFFFF_0000);
    awaddr = 32'h00; wdata = 32'h0000_1234; awvalid = 1'b1; wvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check("bresp_held", {29'd0, bvalid, awready, wready}, 32'b100);
      tick();
    end
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    tick();
    tick();
    check("blocked_write_ignored", gpio_out, 32'hA5A5_0F0F);
    check("dir_kept", gpio_oe, 32'hFFFF_0000);

    // Unmapped write is acknowledged and changes nothing
    axi_write(32'h14, 32'hFFFF_FFFF);
    check("unmapped_write_gpio_o", gpio_out, 32'hA5A5_0F0F);

    // Reads, including a stalled rready and unmapped addresses
    gpio_in = 32'h0000_1234;
    repeat (3) tick();
    axi_read(32'h04, 32'h0000_1234, 2);
    axi_read(32'h18, 32'h0, 0);
    axi_read(32'h00, 32'hA5A5_0F0F, 0);
    axi_read(32'h08, 32'hFFFF_0000, 1);

`ifdef GPIO_IRQ_EN
    axi_write(32'h0C, 32'h1);
    axi_read(32'h0C, 32'h1, 0);
    gpio_in = 32'h0000_1235;
    repeat (4) tick();
    check("irq_set", {31'd0, irq}, 32'd1);
    axi_read(32'h10, 32'h1, 0);
    axi_write(32'h10, 32'h1);
    check("irq_cleared", {31'd0, irq}, 32'd0);
    axi_read(32'h10, 32'h0, 0);
    gpio_in = 32'h0000_1234;
    repeat (4) tick();
    check("irq_no_fall_set", {31'd0, irq}, 32'd0);
    // Rise reaches the edge detector on the same edge the clear commits
    gpio_in = 32'h0000_1235;
    tick();
    tick();
    axi_write(32'h10, 32'h1);
    check("irq_set_wins", {31'd0, irq}, 32'd1);
    axi_read(32'h10, 32'h1, 0);
    axi_write(32'h10, 32'h1);
    check("irq_final_clear", {31'd0, irq}, 32'd0);
`else
    axi_write(32'h0C, 32'h1);
    gpio_in = 32'h0000_1235;
    repeat (4) tick();
    axi_read(32'h0C, 32'h0, 0);
    axi_read(32'h10, 32'h0, 0);
    check("irq_tied_low", {31'd0, irq}, 32'd0);
`endif

    // Read and write of DATA_OUT committing on the same edge
    axi_write(32'h00, 32'h0);
    exp_r_q.push_back(32'h0);
    exp_b_q.push_back(0);
    awaddr = 32'h00; wdata = 32'h5; araddr = 32'h00;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; bready = 1'b1; rready = 1'b1;
    @(negedge clk_i);
    check("conc_readies", {29'd0, awready, wready, arready}, 32'd7);
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    @(negedge clk_i);
    check("conc_valids", {30'd0, bvalid, rvalid}, 32'd3);
    tick();
    rready = 1'b0;
    check("conc_gpio_o", gpio_out, 32'h5);
    axi_read(32'h00, 32'h5, 1);

    repeat (2) tick();
    check("r_queue_drained", exp_r_q.size(), 32'd0);
    check("b_queue_drained", exp_b_q.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/axil_gpio_slave.md
# axil_gpio_slave

AXI-Lite responder exposing a GPIO port to the nano_rv32i core's LSU MMIO path. It accepts the core's reduced AXI-Lite subset (no strobes, no response codes) and decodes a five-register word map. Output data and per-bit direction are driven to pads, and pad inputs are synchronized. An optional edge interrupt is provided. It sits between the core's s_axi_* ports and the board GPIO pins.

## Interface
- GPIO_W, 32: GPIO bit count, 1..32; register bits above GPIO_W read 0 and ignore writes.
- clk_i  in  1  clock
- rst_n_i  in  1  reset, asynchronous, active-low
- s_axi_awaddr_i  in  32  write address; only [4:2] decoded
- s_axi_awvalid_i  in  1  write address valid
- s_axi_awready_o  out  1  write address accepted
- s_axi_wdata_i  in  32  write data, full-word only
- s_axi_wvalid_i  in  1  write data valid
- s_axi_wready_o  out  1  write data accepted
- s_axi_bvalid_o  out  1  write response valid
- s_axi_bready_i  in  1  write response accepted
- s_axi_araddr_i  in  32  read address; only [4:2] decoded
- s_axi_arvalid_i  in  1  read address valid
- s_axi_arready_o  out  1  read address accepted
- s_axi_rdata_o  out  32  read data
- s_axi_rvalid_o  out  1  read data valid
- s_axi_rready_i  in  1  read data accepted
- gpio_i  in  GPIO_W  pad inputs, asynchronous
- gpio_o  out  GPIO_W  pad output data (DATA_OUT)
- gpio_oe_o  out  GPIO_W  pad output enable, 1 = drive (DIR)
- irq_o  out  1  level interrupt

## Operation
- Register map (byte offset): 0x00 DATA_OUT RW, 0x04 DATA_IN RO, 0x08 DIR RW, 0x0C IRQ_EN RW, 0x10 IRQ_STAT W1C; 0x14..0x1C unmapped: read 0, write ignored, handshake still completes.
- DATA_IN: gpio_i through 2-flop synchronizer; writes ignored.
- Write FSM states W_IDLE, W_RESP. In W_IDLE, awready=1 until AW captured, wready=1 until W captured; AW and W may arrive same cycle or in either order, other channel waits with ready=1. Edge at which both are held: register written, state→W_RESP. W_RESP: bvalid=1, awready=wready=0; on bvalid&&bready → W_IDLE.
- Read FSM states R_IDLE, R_DATA. R_IDLE: arready=1; on arvalid → rdata registered from decoded address, state→R_DATA. R_DATA: rvalid=1, arready=0, rdata held stable; on rready → R_IDLE.
- Read and write FSMs independent; both may be active simultaneously.
- Reset (any time, incl. mid-transaction): all registers and FSMs to idle/0; in-flight transaction dropped, no response issued.

## Timing
- All outputs 0 while rst_n_i low (readies included); awready/wready/arready = 1 from first cycle after release.
- Write: register, gpio_o/gpio_oe_o update after commit edge N; bvalid=1 from cycle N+1.
- Read: arvalid&&arready at edge N → rvalid=1, rdata valid in cycle N+1. Minimum back-to-back read spacing 2 cycles.
- Read committed in same cycle as a write commit to same register returns old value.
- gpio_i change visible in DATA_IN 2 edges later; IRQ_STAT set 1 edge after that.

## Configuration
- GPIO_IRQ_EN defined: per bit, rising edge of synchronized input with IRQ_EN bit set → IRQ_STAT bit set; writing 1 clears bit; set and clear same cycle → set wins; irq_o = |(IRQ_STAT & IRQ_EN), registered.
- GPIO_IRQ_EN undefined: IRQ_EN/IRQ_STAT behave as unmapped (read 0, writes ignored), no edge logic, irq_o tied 0.

## Test plan
- Reset mid-write (AW accepted, W pending) → after release bvalid=0, DATA_OUT=0, awready=wready=1.
- AW and W same cycle, addr 0x00, data 0xA5A5_0F0F, bready=1 → gpio_o=0xA5A5_0F0F next cycle, single bvalid pulse.
- W two cycles before AW, addr 0x08, data 0xFFFF_0000, bready held 0 for 3 cycles → gpio_oe_o updates on AW edge, bvalid held 3 cycles, no second write accepted meanwhile.
- gpio_i=0x0000_1234, read 0x04 with rready stalled 2 cycles → rdata=0x0000_1234 stable while rvalid; read 0x18 → 0.
- GPIO_IRQ_EN: IRQ_EN=0x1, gpio_i[0] 0→1 → IRQ_STAT=0x1, irq_o=1; write 0x1 to 0x10 → irq_o=0; edge on same cycle as clear → stays 1.
- Concurrent read of 0x00 and write of 0x00 (0x5) committing same edge → rdata returns prior value 0, subsequent read returns 0x5.
